progmem_arbiter: RTL

PROGMEM_ARBITER -- requirements
Module: progmem_arbiter

---
 rtl/progmem_arbiter_pkg.sv | 29 ++
 rtl/progmem_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/progmem_arbiter_pkg.sv
// Shared definitions for the program-memory arbiter: state encoding,
// grant codes, default timing/error constants and the round-robin pick.
package progmem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int          DEF_TIMEOUT  = 15;
  localparam logic [31:0] DEF_ERR_DATA = 32'hFFFF_FFFF;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // Round-robin choice: on a tie the port that did not win last time goes
  // next; a lone requester always wins.
  function automatic logic [1:0] rr_pick(input logic v0, input logic v1,
                                         input logic last_m1);
    logic [1:0] g;
    g = GNT_NONE;
    if (v0 && v1) g = last_m1 ? GNT_M0 : GNT_M1;
    else if (v0)  g = GNT_M0;
    else if (v1)  g = GNT_M1;
    return g;
  endfunction

endpackage

// File: rtl/progmem_arbiter.sv
// Two-port arbiter in front of a single program-memory port.
// m0 is the CPU fetch port, m1 the loader/debug port.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; a pending request is granted on the next edge
// BUSY  | granted port drives the memory; ends on mem_ready or timeout
module progmem_arbiter
  import progmem_arbiter_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          TIMEOUT    = DEF_TIMEOUT,
  parameter logic [31:0] ERR_DATA   = DEF_ERR_DATA
) (
  input  logic                  clk,
  input  logic                  rstn,

  input  logic                  m0_valid,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  output logic                  m0_ready,
  output logic [31:0]           m0_rdata,

  input  logic                  m1_valid,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic                  m1_ready,
  output logic [31:0]           m1_rdata,

  output logic                  mem_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata,

  output logic [1:0]            grant,
  output logic                  timeout_err
);

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  state_t     state;
  logic       last_m1;
  logic [7:0] wait_cnt;

  logic       busy;
  logic       wait_expired;
  logic       done;
  logic [31:0] rsp_data;

  assign busy         = (state == ST_BUSY);
  assign wait_expired = busy && (wait_cnt == TIMEOUT_CNT);
  // A real response in the expiry cycle takes precedence over the timeout.
  assign done         = busy && (mem_ready || wait_expired);
  assign timeout_err  = wait_expired && !mem_ready;
  assign rsp_data     = mem_ready ? mem_rdata : ERR_DATA;

  assign mem_valid = busy && !mem_ready;

  assign m0_ready = done && (grant == GNT_M0);
  assign m1_ready = done && (grant == GNT_M1);
  assign m0_rdata = m0_ready ? rsp_data : 32'h0;
  assign m1_rdata = m1_ready ? rsp_data : 32'h0;

  // Arbitration FSM: grant on leaving IDLE, count wait cycles in BUSY,
  // release the port on response or timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      grant    <= GNT_NONE;
      last_m1  <= 1'b1;
      wait_cnt <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m0_valid || m1_valid) begin
            grant    <= rr_pick(m0_valid, m1_valid, last_m1);
            last_m1  <= rr_pick(m0_valid, m1_valid, last_m1) == GNT_M1;
            wait_cnt <= 8'd0;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem_ready || wait_expired) begin
            grant    <= GNT_NONE;
            wait_cnt <= 8'd0;
            state    <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  // Memory request mux follows the owner; nothing is driven without one.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    case (grant)
      GNT_M0: begin
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_wstrb = m0_wstrb;
      end
      GNT_M1: begin
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        mem_wstrb = m1_wstrb;
      end
      default: begin
        mem_addr  = '0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
      end
    endcase
  end

endmodule
